// File: rtl/comms_rx_data_path.sv
// Receive data path: reassembles one {src,len} framed packet stream into a local buffer,
// acks the sender, then streams the words to the GPP. Optional macro: COMMS_RX_TIMEOUT_EN.
module comms_rx_data_path #(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] node_id,
    input  logic [31:0] data_rx_packet,
    input  logic        data_rx_valid,
    input  logic        gpp_rtr_dp,
    output logic [15:0] RAM_rx_data_out,
    output logic        data_rx_flag,
    output logic [15:0] data_rx_node_id,
    output logic [31:0] control_tx_packet,
    output logic        rx_err
);
    // DEPTH must be >= 2; the extra pointer bit lets wr_ptr reach len == DEPTH
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {IDLE, RECV, ACK, READY} state_t;

    state_t         state, next_state;
    logic [15:0]    src;
    logic [PW-1:0]  len, wr_ptr, rd_ptr;
    logic [15:0]    ram [DEPTH];

    logic           hdr_take, wr_en, rd_en, rd_last, drop, timeout;
    logic           full, accept, hdr_ok;

    assign full    = (wr_ptr == len);
    assign accept  = data_rx_valid && (data_rx_packet[31:16] == src);
    assign hdr_ok  = (data_rx_packet[15:0] != 16'd0) && (data_rx_packet[15:0] <= 16'(DEPTH));
    assign rd_last = (rd_ptr == len - PW'(1));

    assign data_rx_flag    = (state == READY);
    assign data_rx_node_id = (state == READY) ? src : 16'd0;

`ifdef COMMS_RX_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] tmo_cnt;

    // Counts consecutive RECV cycles without an accepted payload word
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tmo_cnt <= '0;
        else if (state != RECV || accept)
            tmo_cnt <= '0;
        else
            tmo_cnt <= tmo_cnt + CW'(1);
    end

    assign timeout = (state == RECV) && !full && !accept && (tmo_cnt == CW'(TIMEOUT - 1));
`else
    // No abort path in this build; a stalled frame waits indefinitely
    assign timeout = (TIMEOUT < 0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        hdr_take   = 1'b0;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        drop       = 1'b0;
        case (state)
            IDLE: begin
                if (data_rx_valid) begin
                    if (hdr_ok) begin
                        hdr_take   = 1'b1;
                        next_state = RECV;
                    end else begin
                        drop = 1'b1;
                    end
                end
            end
            RECV: begin
                if (full) begin
                    next_state = ACK;
                    drop       = data_rx_valid;
                end else if (accept) begin
                    wr_en = 1'b1;
                end else begin
                    drop = data_rx_valid;
                    if (timeout) next_state = IDLE;
                end
            end
            ACK: begin
                next_state = READY;
                drop       = data_rx_valid;
            end
            READY: begin
                drop = data_rx_valid;
                if (gpp_rtr_dp) begin
                    rd_en = 1'b1;
                    if (rd_last) next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src               <= '0;
            len               <= '0;
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            RAM_rx_data_out   <= '0;
            control_tx_packet <= '0;
            rx_err            <= 1'b0;
        end else begin
            rx_err            <= drop | timeout;
            control_tx_packet <= '0;
            if (state == RECV && full)
                control_tx_packet <= {node_id, 16'hFFFF};
            if (timeout) begin
                control_tx_packet <= {node_id, 16'h0000};
                wr_ptr            <= '0;
            end
            if (hdr_take) begin
                src    <= data_rx_packet[31:16];
                len    <= data_rx_packet[PW-1:0];
                wr_ptr <= '0;
                rd_ptr <= '0;
            end
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            if (rd_en) begin
                RAM_rx_data_out <= ram[rd_ptr[AW-1:0]];
                if (rd_last) begin
                    rd_ptr <= '0;
                    wr_ptr <= '0;
                end else begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) ram[wr_ptr[AW-1:0]] <= data_rx_packet[15:0];
    end

endmodule
